// File: rtl/instruction_sequencer_if.sv
// Sequencer bus: instruction ROM port, run request and
// datapath control strobes.
interface instruction_sequencer_if #(
  parameter int PC_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
);
  logic                 run;
  logic [7:0]           instr_data;
  logic [PC_WIDTH-1:0]  instr_addr;
  logic [7:0]           instruction;
  logic                 regdst;
  logic                 regwrite;
  logic                 alusrc;
  logic                 memread;
  logic                 memwrite;
  logic                 memtoreg;
  logic                 halted;
  logic [CNT_WIDTH-1:0] instr_count;

  modport master (
    input  run,
    input  instr_data,
    output instr_addr,
    output instruction,
    output regdst,
    output regwrite,
    output alusrc,
    output memread,
    output memwrite,
    output memtoreg,
    output halted,
    output instr_count
  );

  modport slave (
    output run,
    output instr_data,
    input  instr_addr,
    input  instruction,
    input  regdst,
    input  regwrite,
    input  alusrc,
    input  memread,
    input  memwrite,
    input  memtoreg,
    input  halted,
    input  instr_count
  );
endinterface

// File: rtl/instruction_sequencer.sv
// Multi-cycle fetch/decode/exec/writeback sequencer for the
// 8-bit, 4-register datapath.
module instruction_sequencer #(
  parameter int PC_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
) (
  input logic                     CLK,
  input logic                     RESET_N,
  instruction_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_e;

  localparam logic [PC_WIDTH-1:0] PC_ONE =
    PC_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [7:0]           ir_q, ir_d;
  logic                 halted_q, halted_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                 is_add;
  logic                 is_lw;
  logic                 is_sw;
  logic                 is_jmp;
  logic [PC_WIDTH-1:0]  jmp_off;

  logic regdst;
  logic regwrite;
  logic alusrc;
  logic memread;
  logic memwrite;
  logic memtoreg;

  assign is_add = (ir_q[7:6] == 2'b00);
  assign is_lw  = (ir_q[7:6] == 2'b01);
  assign is_sw  = (ir_q[7:6] == 2'b10);
  assign is_jmp = (ir_q[7:6] == 2'b11);

  // PC already points past the JMP, so the
  // target is pc_q + offset.
  assign jmp_off = {{(PC_WIDTH-6){ir_q[5]}},
                    ir_q[5:0]};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= FETCH;
      pc_q     <= '0;
      ir_q     <= 8'h00;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    regdst   = 1'b0;
    regwrite = 1'b0;
    alusrc   = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    memtoreg = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (bus.run && !halted_q) begin
          ir_d    = bus.instr_data;
          pc_d    = pc_q + PC_ONE;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = EXEC;
      end
      EXEC: begin
        unique case (1'b1)
          is_add: begin
            regdst  = 1'b1;
            state_d = WB;
          end
          is_lw: begin
            alusrc   = 1'b1;
            memread  = 1'b1;
            memtoreg = 1'b1;
            state_d  = WB;
          end
          is_sw: begin
            alusrc   = 1'b1;
            memwrite = 1'b1;
            cnt_d    = cnt_q + CNT_ONE;
            state_d  = FETCH;
          end
          is_jmp: begin
            pc_d     = pc_q + jmp_off;
            halted_d = halted_q |
                       (ir_q[5:0] == 6'h3F);
            cnt_d    = cnt_q + CNT_ONE;
            state_d  = FETCH;
          end
          default: state_d = FETCH;
        endcase
      end
      WB: begin
        regwrite = 1'b1;
        regdst   = is_add;
        memtoreg = is_lw;
        memread  = is_lw;
        cnt_d    = cnt_q + CNT_ONE;
        state_d  = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  assign bus.instr_addr  = pc_q;
  assign bus.instruction = ir_q;
  assign bus.halted      = halted_q;
  assign bus.instr_count = cnt_q;
  assign bus.regdst      = regdst;
  assign bus.regwrite    = regwrite;
  assign bus.alusrc      = alusrc;
  assign bus.memread     = memread;
  assign bus.memwrite    = memwrite;
  assign bus.memtoreg    = memtoreg;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer: per-cycle
// expectations queued per instruction, popped each cycle.
module tb_instruction_sequencer;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;

  instruction_sequencer_if #(
    .PC_WIDTH(8),
    .CNT_WIDTH(16)
  ) bus ();

  instruction_sequencer #(
    .PC_WIDTH(8),
    .CNT_WIDTH(16)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  logic [7:0] rom [256];
  assign bus.instr_data = rom[bus.instr_addr];

  typedef struct {
    string      tag;
    logic [5:0] ctrl;
    logic [7:0] pc;
    logic [7:0] ir;
    logic [15:0] cnt;
    logic       halt;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  pc_m;
  logic [7:0]  ir_m;
  logic [15:0] cnt_m;
  logic        halt_m;

  logic [5:0] ctrl_obs;
  assign ctrl_obs = {bus.regdst, bus.regwrite,
                     bus.alusrc, bus.memread,
                     bus.memwrite, bus.memtoreg};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // {regdst,regwrite,alusrc,memread,memwrite,memtoreg}
  function automatic logic [5:0] exp_ctrl(
    input logic [1:0] op, input bit wb);
    if (!wb) begin
      case (op)
        2'b00:   return 6'b100000;
        2'b01:   return 6'b001101;
        2'b10:   return 6'b001010;
        default: return 6'b000000;
      endcase
    end else begin
      case (op)
        2'b00:   return 6'b110000;
        2'b01:   return 6'b010101;
        default: return 6'b000000;
      endcase
    end
  endfunction

  function automatic exp_t mk(
    input string tag, input logic [5:0] c,
    input logic [7:0] p, input logic [7:0] i);
    exp_t e;
    e.tag  = $sformatf("%s@%0h", tag, pc_m);
    e.ctrl = c;
    e.pc   = p;
    e.ir   = i;
    e.cnt  = cnt_m;
    e.halt = halt_m;
    return e;
  endfunction

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, "_ctrl"}, 32'(ctrl_obs), 32'(e.ctrl));
      chk({e.tag, "_pc"}, 32'(bus.instr_addr),
          32'(e.pc));
      chk({e.tag, "_ir"}, 32'(bus.instruction),
          32'(e.ir));
      chk({e.tag, "_cnt"}, 32'(bus.instr_count),
          32'(e.cnt));
      chk({e.tag, "_halt"}, 32'(bus.halted),
          32'(e.halt));
    end
  end

  // Call just after a rising edge with the DUT in FETCH.
  task automatic do_instr(input bit drop_run);
    logic [7:0] w;
    logic [7:0] p1;
    logic [1:0] op;
    int n;
    w  = rom[pc_m];
    op = w[7:6];
    p1 = pc_m + 8'd1;
    n  = (op == 2'b00 || op == 2'b01) ? 4 : 3;
    sb.push_back(mk("F", 6'b0, pc_m, ir_m));
    sb.push_back(mk("D", 6'b0, p1, w));
    sb.push_back(mk("E", exp_ctrl(op, 1'b0), p1, w));
    if (n == 4)
      sb.push_back(mk("W", exp_ctrl(op, 1'b1), p1, w));
    bus.run = 1'b1;
    @(posedge CLK); #1;
    if (drop_run) bus.run = 1'b0;
    repeat (n - 1) @(posedge CLK);
    #1;
    pc_m = p1;
    if (op == 2'b11) begin
      pc_m = p1 + {{2{w[5]}}, w[5:0]};
      if (w[5:0] == 6'h3F) halt_m = 1'b1;
    end
    ir_m  = w;
    cnt_m = cnt_m + 16'd1;
  endtask

  task automatic do_reset();
    bus.run = 1'b0;
    @(posedge CLK); #1;
    RESET_N = 1'b0;
    #1;
    chk("rst_pc", 32'(bus.instr_addr), 32'h0);
    chk("rst_ir", 32'(bus.instruction), 32'h0);
    chk("rst_halt", 32'(bus.halted), 32'h0);
    chk("rst_cnt", 32'(bus.instr_count), 32'h0);
    chk("rst_ctrl", 32'(ctrl_obs), 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    pc_m   = 8'h00;
    ir_m   = 8'h00;
    cnt_m  = 16'd0;
    halt_m = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    bus.run = 1'b0;
    pc_m    = 8'h00;
    ir_m    = 8'h00;
    cnt_m   = 16'd0;
    halt_m  = 1'b0;

    #1;
    chk("por_pc", 32'(bus.instr_addr), 32'h0);
    chk("por_ctrl", 32'(ctrl_obs), 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;

    rom[0] = 8'h1B;
    rom[1] = 8'h56;
    rom[2] = 8'hA7;
    rom[3] = 8'h00;
    rom[4] = 8'hC2;
    rom[7] = 8'hC1;
    rom[9] = 8'hFF;

    do_instr(1'b0);
    chk("add_pc", 32'(bus.instr_addr), 32'h1);
    chk("add_cnt", 32'(bus.instr_count), 32'h1);
    for (int k = 0; k < 6; k++) do_instr(1'b0);
    chk("halt_pc0", 32'(bus.instr_addr), 32'h9);
    chk("halt_cnt0", 32'(bus.instr_count), 32'h7);

    bus.run = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      chk("halt_pc", 32'(bus.instr_addr), 32'h9);
      chk("halt_cnt", 32'(bus.instr_count), 32'h7);
      chk("halt_flag", 32'(bus.halted), 32'h1);
      chk("halt_ir", 32'(bus.instruction), 32'hFF);
      chk("halt_ctrl", 32'(ctrl_obs), 32'h0);
    end
    do_reset();

    do_instr(1'b1);
    repeat (3) begin
      @(negedge CLK);
      chk("park_pc", 32'(bus.instr_addr), 32'h1);
      chk("park_cnt", 32'(bus.instr_count), 32'h1);
      chk("park_ir", 32'(bus.instruction), 32'h1B);
      chk("park_ctrl", 32'(ctrl_obs), 32'h0);
    end
    @(posedge CLK); #1;
    do_instr(1'b0);
    chk("resume_pc", 32'(bus.instr_addr), 32'h2);
    do_reset();

    bus.run = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    bus.run = 1'b0;
    #2;
    chk("wb_regwrite", 32'(bus.regwrite), 32'h1);
    chk("wb_pc", 32'(bus.instr_addr), 32'h1);
    RESET_N = 1'b0;
    #1;
    chk("arst_regwrite", 32'(bus.regwrite), 32'h0);
    chk("arst_regdst", 32'(bus.regdst), 32'h0);
    chk("arst_pc", 32'(bus.instr_addr), 32'h0);
    chk("arst_cnt", 32'(bus.instr_count), 32'h0);
    chk("arst_ir", 32'(bus.instruction), 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    pc_m   = 8'h00;
    ir_m   = 8'h00;
    cnt_m  = 16'd0;
    halt_m = 1'b0;

    rom[0]   = 8'hFE;
    rom[255] = 8'h00;
    do_instr(1'b0);
    chk("jmp_back_pc", 32'(bus.instr_addr), 32'hFF);
    do_instr(1'b0);
    chk("inc_wrap_pc", 32'(bus.instr_addr), 32'h0);
    do_instr(1'b0);
    rom[255] = 8'hC1;
    do_instr(1'b0);
    chk("jmp_wrap_pc", 32'(bus.instr_addr), 32'h1);
    chk("jmp_wrap_cnt", 32'(bus.instr_count), 32'h4);

    @(negedge CLK);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Multi-cycle fetch/decode/control FSM for the 8-bit, 4-register datapath. Holds the program counter and instruction register, and presents instruction bits [5:0] as the register-file address fields. Drives the register file's `regdst`/`regwrite` strobes plus the ALU and data-memory controls. It sequences each instruction around the register file's clocked read (read data valid one edge after the addresses are presented).

## Interface
- `PC_WIDTH`, 8: program counter / instruction address width
- `CNT_WIDTH`, 16: retired-instruction counter width
- `CLK` in 1: single clock, all state updates on rising edge
- `RESET_N` in 1: reset, asynchronous, active-low
- `run` in 1: 1 = sequencer may start a new instruction
- `instr_data` in 8: instruction word from instruction ROM, combinational read of `instr_addr`
- `instr_addr` out PC_WIDTH: current PC
- `instruction` out 8: instruction register; [7:6] opcode, [5:4] rs, [3:2] rt, [1:0] rd/imm
- `regdst` out 1: 1 = write rd, 0 = write rt
- `regwrite` out 1: register-file write strobe
- `alusrc` out 1: 1 = ALU B operand is sign-extended `instruction[1:0]`
- `memread` out 1: data-memory read
- `memwrite` out 1: data-memory write
- `memtoreg` out 1: 1 = write-back data from memory, 0 = from ALU
- `halted` out 1: sticky halt flag
- `instr_count` out CNT_WIDTH: retired instructions

## Operation
- Opcodes:
  - 00 ADD: rd = rs + rt
  - 01 LW: rt = mem[rs + sext(imm)]
  - 10 SW: mem[rs + sext(imm)] = rt
  - 11 JMP: PC = PC + 1 + sext(`instruction[5:0]`)
- States are FETCH, DECODE, EXEC and WB, with 2-bit encoding.
- **FETCH**
  - If `run`=1 and `halted`=0: IR <= `instr_data`, PC <= PC+1 (mod 2^PC_WIDTH), go to DECODE.
  - Otherwise stay in FETCH; PC and IR hold.
- **DECODE**: no strobes asserted; register file samples the rs/rt fields at this state's closing edge. Always go to EXEC.
- **EXEC**
  - ADD: `regdst`=1; go to WB.
  - LW: `alusrc`=1, `memread`=1; go to WB.
  - SW: `alusrc`=1, `memwrite`=1; retire; go to FETCH.
  - JMP: PC <= PC + sext6(offset), wrap mod 2^PC_WIDTH; retire; go to FETCH. Offset 6'h3F (jump-to-self) also sets `halted`.
- **WB**: `regwrite`=1 for exactly one cycle.
  - ADD: `regdst`=1, `memtoreg`=0.
  - LW: `regdst`=0, `memtoreg`=1, `memread`=1.
  - Retire; go to FETCH.
- Control outputs are decoded from state and IR only. `regdst`/`memtoreg` are held at their WB values through EXEC and WB; all strobes are 0 in FETCH and DECODE.
- Retire means `instr_count` += 1 at the closing edge, wrapping at 2^CNT_WIDTH.
- `run` is sampled only in FETCH. Deasserting it mid-instruction lets the instruction complete.
- `halted` clears only on reset. While halted, the FSM stays in FETCH, no fetch occurs, and `instr_count` freezes.

## Timing
- Reset (async, immediate): PC=0, IR=8'h00, state=FETCH, `halted`=0, `instr_count`=0. All strobes 0, including mid-WB, so a pending write is dropped.
- Latency from FETCH entry with `run`=1:
  - ADD/LW: 4 cycles.
  - SW/JMP: 3 cycles.
  - Next FETCH follows immediately; no bubble.
- `regwrite` is high only during WB. The register file commits at the WB→FETCH edge.
- `memwrite` is high for exactly the one EXEC cycle.
- PC wraps 255→0 on increment. JMP target arithmetic wraps: PC=8'hFF, offset=+1 lands at 8'h01.
- Reset released mid-cycle: the first action is a FETCH of address 0 on the first edge with `run`=1.

## Test plan
- Reset, ROM[0]=8'h1B (ADD rd=3, rs=1, rt=2), `run`=1 → states FETCH/DECODE/EXEC/WB; `regwrite`=1 and `regdst`=1 in cycle 4 only; `instr_addr`=1 at next FETCH; `instr_count`=1.
- ROM[0]=8'h56 (LW rs=1, rt=1, imm=2), ROM[1]=8'hA7 (SW) → LW: `memread` in EXEC+WB, `regwrite` in WB with `regdst`=0, `memtoreg`=1. SW: `memwrite` one cycle, no `regwrite`, 3 cycles total; `instr_count`=2.
- ROM[4]=8'hC2 (JMP +2) → `instr_addr` goes 4→5→7; 3 cycles; no strobes asserted.
- ROM[9]=8'hFF (JMP -1) → PC returns to 9, `halted`=1; further cycles with `run`=1 leave PC=9 and `instr_count` frozen; `RESET_N`=0 clears `halted` and PC.
- Drop `run` during DECODE of an ADD → ADD completes WB; FSM parks in FETCH with PC held; re-raising `run` resumes fetch at the same PC.
- Assert `RESET_N`=0 asynchronously during WB of an ADD → `regwrite` falls before the next edge, state=FETCH, PC=0, `instr_count`=0; ROM entry at 8'hFF=8'h00 executed with PC=8'hFF → PC wraps to 0.
